regfile_seq: RTL and testbench
==============================

// Module: regfile_seq
// PURPOSE
//  Register-file control sequencer for the RNBIP-2 datapath. Accepts one 8-bit
//  register-transfer opcode per valid/ready handshake and drives the dual-port
//  register file's we/mux_sel/write_seg/read_seg over 1..N cycles. Also owns the
//  stack pointer and the memory-read handshake for LOAD.
// PARAMETERS
//  SP_RESET     8'hFF  stack pointer value after reset
//  ALU_LAT      1      wait cycles between ALU-writeback accept and write (>=0)
//  MEM_TIMEOUT  16     mem_ack wait limit in cycles (used only with REGSEQ_MEMTO_EN)
// PORTS
//  clk          in   1  clock, all state on rising edge
//  clr          in   1  asynchronous active-high reset
//  instr        in   8  opcode {cls[7:6], rn[5:3], sub[2:0]}
//  instr_valid  in   1  opcode valid
//  instr_ready  out  1  sequencer idle, opcode accepted when valid&&ready
//  mem_ack      in   1  memory data valid on regfile mem input (1-cycle pulse)
//  mem_rd       out  1  memory read request, held until mem_ack
//  we           out  1  regfile write enable
//  mux_sel      out  3  regfile write source select
//  write_seg    out  3  regfile write index
//  read_seg     out  3  regfile port-B read index
//  sp           out  8  stack pointer, drives regfile SP input
//  rd_valid     out  1  regfile dataout_B holds the requested Rn this cycle
//  err          out  1  1-cycle pulse: illegal opcode or memory timeout
// BEHAVIOUR
//  Reset: state IDLE, instr_ready=1, we=0, mux_sel=0, write_seg=0, read_seg=0,
//   mem_rd=0, rd_valid=0, err=0, sp=SP_RESET. Reset mid-operation drops any
//   pending write or read; no write is issued afterwards.
//  States: IDLE, ALU_WAIT, MEM_WAIT, WRITE, READ, RDONE, ERR.
//  instr_ready=1 only in IDLE; instr_valid is ignored in all other states.
//  Decode at accept edge (cls=00):
//   sub 000/001/010 MOV Rn<-A/B/OR2 -> WRITE, mux_sel=sub, write_seg=rn
//   sub 011 ALU writeback -> ALU_WAIT for ALU_LAT cycles (0: direct) -> WRITE mux 011
//   sub 100 POP: WRITE mux 100, write_seg=0; sp<=sp+1 at end of WRITE cycle
//   sub 101 R0<-B: WRITE mux 101, write_seg=0
//   sub 110 LOAD: MEM_WAIT with mem_rd=1; on mem_ack -> WRITE mux 110, mem_rd=0
//   sub 111 -> ERR
//  cls=01 READ Rn: READ (read_seg=rn) -> RDONE (rd_valid=1, read_seg held) -> IDLE
//  cls=10 PUSH: sp<=sp-1 at accept edge, stays IDLE (ready stays 1)
//  cls=11 -> ERR
//  WRITE: we=1 exactly one cycle with mux_sel/write_seg stable; -> IDLE.
//   we, mux_sel, write_seg are registered (no glitches); regfile captures at
//   the edge ending WRITE. MOV latency: accept edge E0, we high E0..E1, Rn updated
//   at E1, instr_ready high again after E1.
//  ERR: err=1 one cycle, no write, -> IDLE.
//  read_seg holds last value outside READ/RDONE; we=0 outside WRITE.
//  sp wraps modulo 256 (8'hFF+1=8'h00, 8'h00-1=8'hFF), no error flagged.
//  mem_ack outside MEM_WAIT is ignored; mem_ack in the request cycle counts.
// CONFIGURATION
//  REGSEQ_MEMTO_EN defined: MEM_WAIT has a cycle counter; if MEM_TIMEOUT cycles
//   elapse without mem_ack, mem_rd drops, -> ERR (err pulse), no write.
//  Not defined: MEM_WAIT waits indefinitely for mem_ack; MEM_TIMEOUT unused.
// TESTING
//  clr pulse mid-LOAD (mem_rd=1) -> all outputs at reset values, sp=8'hFF, no we
//  instr=8'b00_011_001 -> next cycle we=1, mux_sel=001, write_seg=011, one cycle only
//  LOAD R5 (8'b00_101_110), mem_ack after 3 cycles -> mem_rd 3 cycles, then we=1 mux 110 seg 5
//  PUSH x2 then POP -> sp FF->FE->FD; POP writes R0 with mux 100, sp->FE
//  READ R2 (8'b01_010_000) -> read_seg=2, rd_valid=1 one cycle later; instr=8'hC0 -> err pulse
//  With REGSEQ_MEMTO_EN, LOAD, no mem_ack -> err after 16 cycles, we never asserted

Source files
------------

// File: rtl/regfile_seq.sv
// rtl/regfile_seq.sv - register-file control sequencer for the RNBIP-2 datapath
//
// Takes one 8-bit register-transfer opcode {cls[7:6], rn[5:3], sub[2:0]} per
// instr_valid/instr_ready handshake and sequences the dual-port register file
// (we/mux_sel/write_seg/read_seg) over one or more cycles. Also owns the stack
// pointer and the memory-read handshake used by LOAD.
//
// Optional feature: define REGSEQ_MEMTO_EN to bound the LOAD wait. After
// MEM_TIMEOUT cycles without mem_ack the request is dropped and err pulses.
// Without it, LOAD waits for mem_ack indefinitely.
//
// Ports:
//   clk          in   1  clock, all state on rising edge
//   clr          in   1  asynchronous active-high reset
//   instr        in   8  opcode {cls, rn, sub}
//   instr_valid  in   1  opcode valid
//   instr_ready  out  1  high only when idle; accept on valid && ready
//   mem_ack      in   1  memory data valid (1-cycle pulse)
//   mem_rd       out  1  memory read request, held until mem_ack
//   we           out  1  regfile write enable (registered)
//   mux_sel      out  3  regfile write source select (registered)
//   write_seg    out  3  regfile write index (registered)
//   read_seg     out  3  regfile port-B read index
//   sp           out  8  stack pointer
//   rd_valid     out  1  port-B data holds the requested register this cycle
//   err          out  1  1-cycle pulse on illegal opcode or memory timeout

module regfile_seq #(
    parameter logic [7:0] SP_RESET    = 8'hFF,
    parameter int         ALU_LAT     = 1,
    parameter int         MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic       mem_ack,
    output logic       mem_rd,
    output logic       we,
    output logic [2:0] mux_sel,
    output logic [2:0] write_seg,
    output logic [2:0] read_seg,
    output logic [7:0] sp,
    output logic       rd_valid,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALU_WAIT,
        S_MEM_WAIT,
        S_WRITE,
        S_READ,
        S_RDONE,
        S_ERR
    } state_t;

    // One counter serves both wait states (ALU countdown, memory timeout),
    // so it is sized for the larger of the two limits.
    localparam int CNT_MAX = (ALU_LAT > MEM_TIMEOUT) ? ALU_LAT : MEM_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [2:0] SUB_ALU  = 3'b011;
    localparam logic [2:0] SUB_POP  = 3'b100;
    localparam logic [2:0] SUB_R0B  = 3'b101;
    localparam logic [2:0] SUB_LOAD = 3'b110;
    localparam logic [2:0] SUB_ILL  = 3'b111;

    state_t           state, state_d;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic [2:0]       mux_sel_d, write_seg_d, read_seg_d;
    logic [7:0]       sp_d;

    logic [1:0] cls;
    logic [2:0] rn;
    logic [2:0] sub;
    logic       accept;
    logic       mem_timeout;

    assign cls    = instr[7:6];
    assign rn     = instr[5:3];
    assign sub    = instr[2:0];
    assign accept = instr_valid && (state == S_IDLE);

    assign instr_ready = (state == S_IDLE);

`ifdef REGSEQ_MEMTO_EN
    // wait_cnt starts at 0 in the request cycle, so the last permitted cycle
    // is MEM_TIMEOUT-1; an ack in that cycle still wins.
    assign mem_timeout = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
`else
    assign mem_timeout = 1'b0;
`endif

    // State and registered outputs. The handshake outputs are registered
    // copies of the next-state decode so they never glitch.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            we        <= 1'b0;
            mem_rd    <= 1'b0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
            mux_sel   <= 3'd0;
            write_seg <= 3'd0;
            read_seg  <= 3'd0;
            sp        <= SP_RESET;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_cnt_d;
            we        <= (state_d == S_WRITE);
            mem_rd    <= (state_d == S_MEM_WAIT);
            rd_valid  <= (state_d == S_RDONE);
            err       <= (state_d == S_ERR);
            mux_sel   <= mux_sel_d;
            write_seg <= write_seg_d;
            read_seg  <= read_seg_d;
            sp        <= sp_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    case (cls)
                        2'b00: begin
                            case (sub)
                                SUB_ALU:  state_d = (ALU_LAT == 0) ? S_WRITE : S_ALU_WAIT;
                                SUB_LOAD: state_d = S_MEM_WAIT;
                                SUB_ILL:  state_d = S_ERR;
                                default:  state_d = S_WRITE;
                            endcase
                        end
                        2'b01:   state_d = S_READ;
                        2'b10:   state_d = S_IDLE;   // PUSH completes at accept
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_ALU_WAIT: if (wait_cnt == '0) state_d = S_WRITE;
            S_MEM_WAIT: begin
                if (mem_ack)          state_d = S_WRITE;
                else if (mem_timeout) state_d = S_ERR;
            end
            S_READ:  state_d = S_RDONE;
            S_WRITE: state_d = S_IDLE;
            S_RDONE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the data-carrying registers (write source/index, read
    // index, stack pointer, wait counter).
    always_comb begin
        mux_sel_d   = mux_sel;
        write_seg_d = write_seg;
        read_seg_d  = read_seg;
        sp_d        = sp;
        wait_cnt_d  = wait_cnt;

        if (accept) begin
            case (cls)
                2'b00: begin
                    if (sub != SUB_ILL) begin
                        // Source and index are captured at accept so they are
                        // already stable when we rises, whatever the path.
                        mux_sel_d   = sub;
                        write_seg_d = (sub == SUB_POP || sub == SUB_R0B) ? 3'd0 : rn;
                    end
                    if (sub == SUB_ALU)  wait_cnt_d = CNT_W'(ALU_LAT - 1);
                    if (sub == SUB_LOAD) wait_cnt_d = '0;
                end
                2'b01:   read_seg_d = rn;
                2'b10:   sp_d = sp - 8'd1;
                default: ;
            endcase
        end

        case (state)
            S_ALU_WAIT: wait_cnt_d = wait_cnt - 1'b1;
            S_MEM_WAIT: wait_cnt_d = wait_cnt + 1'b1;
            // POP releases its stack slot once the write has been captured.
            S_WRITE:    if (mux_sel == SUB_POP) sp_d = sp + 8'd1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_seq.sv
// tb/tb_regfile_seq.sv - scoreboard bench for regfile_seq

module tb_regfile_seq;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       mem_ack;
    logic       mem_rd;
    logic       we;
    logic [2:0] mux_sel;
    logic [2:0] write_seg;
    logic [2:0] read_seg;
    logic [7:0] sp;
    logic       rd_valid;
    logic       err;

    regfile_seq #(
        .SP_RESET   (8'hFF),
        .ALU_LAT    (1),
        .MEM_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .mem_ack    (mem_ack),
        .mem_rd     (mem_rd),
        .we         (we),
        .mux_sel    (mux_sel),
        .write_seg  (write_seg),
        .read_seg   (read_seg),
        .sp         (sp),
        .rd_valid   (rd_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int         kind;
        logic [2:0] mux;
        logic [2:0] seg;
        int         cyc;
    } ev_t;

    ev_t q[$];
    int  n_pass  = 0;
    int  n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic push_ev(input int kind, input logic [2:0] mux, input logic [2:0] seg, input int c);
        ev_t e;
        e.kind = kind;
        e.mux  = mux;
        e.seg  = seg;
        e.cyc  = c;
        q.push_back(e);
    endtask

    // Monitor: every output event (write, read-valid, error) pops one
    // expectation and is checked against it.
    logic we_prev  = 1'b0;
    logic err_prev = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        int  kind;
        if (we || rd_valid || err) begin
            kind = we ? K_WR : (rd_valid ? K_RD : K_ERR);
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_event: got we=%0b rd_valid=%0b err=%0b expected none (cycle %0d)",
                         we, rd_valid, err, cyc);
            end else begin
                e = q.pop_front();
                chk("ev_kind", {29'd0, we, rd_valid, err}, (e.kind == K_WR) ? 32'd4 :
                               (e.kind == K_RD) ? 32'd2 : 32'd1);
                chk("ev_cycle", cyc, e.cyc);
                if (e.kind == K_WR) begin
                    chk("ev_mux_sel", {29'd0, mux_sel}, {29'd0, e.mux});
                    chk("ev_write_seg", {29'd0, write_seg}, {29'd0, e.seg});
                end else if (e.kind == K_RD) begin
                    chk("ev_read_seg", {29'd0, read_seg}, {29'd0, e.seg});
                end
                if (kind != e.kind) $display("  event kind %0d vs %0d", kind, e.kind);
            end
        end
        if (we && we_prev) chk("we_single_cycle", 1, 0);
        if (err && err_prev) chk("err_single_cycle", 1, 0);
        we_prev  = we;
        err_prev = err;
    end

    task automatic issue(input logic [7:0] op, output int k);
        int n;
        n = 0;
        @(negedge clk);
        instr       = op;
        instr_valid = 1'b1;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) chk("issue_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        k = cyc;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},     {31'd0, instr_ready}, 1);
        chk({tag, "_we"},        {31'd0, we},          0);
        chk({tag, "_mux_sel"},   {29'd0, mux_sel},     0);
        chk({tag, "_write_seg"}, {29'd0, write_seg},   0);
        chk({tag, "_read_seg"},  {29'd0, read_seg},    0);
        chk({tag, "_mem_rd"},    {31'd0, mem_rd},      0);
        chk({tag, "_rd_valid"},  {31'd0, rd_valid},    0);
        chk({tag, "_err"},       {31'd0, err},         0);
        chk({tag, "_sp"},        {24'd0, sp},          32'hFF);
    endtask

    typedef struct {
        logic [7:0] op;
        logic [2:0] mux;
        logic [2:0] seg;
        int         lat;
    } wvec_t;

    initial begin
        int    k;
        int    cnt;
        wvec_t wv[5];

        clr         = 1'b1;
        instr       = 8'h00;
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        clr = 1'b0;

        // Write-path opcodes: {opcode, mux_sel, write_seg, cycles to we}
        wv[0] = '{8'b00_011_001, 3'b001, 3'd3, 0};   // MOV R3 <- B
        wv[1] = '{8'b00_111_000, 3'b000, 3'd7, 0};   // MOV R7 <- A
        wv[2] = '{8'b00_001_010, 3'b010, 3'd1, 0};   // MOV R1 <- OR2
        wv[3] = '{8'b00_100_011, 3'b011, 3'd4, 1};   // ALU writeback R4
        wv[4] = '{8'b00_110_101, 3'b101, 3'd0, 0};   // R0 <- B, rn ignored
        for (int i = 0; i < 5; i++) begin
            issue(wv[i].op, k);
            push_ev(K_WR, wv[i].mux, wv[i].seg, k + wv[i].lat);
            @(negedge clk);
            chk("busy_ready_low", {31'd0, instr_ready}, 0);
            if (wv[i].lat > 0) chk("alu_wait_no_we", {31'd0, we}, 0);
            repeat (wv[i].lat + 1) @(negedge clk);
            chk("ready_back", {31'd0, instr_ready}, 1);
        end

        // LOAD R5, ack in third request cycle; a MOV offered meanwhile is ignored
        issue(8'b00_101_110, k);
        push_ev(K_WR, 3'b110, 3'd5, k + 3);
        instr       = 8'b00_010_000;
        instr_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_rd) cnt++;
            if (i == 2) begin
                mem_ack     = 1'b1;
                instr_valid = 1'b0;
            end
        end
        chk("load_mem_rd_cycles", cnt, 3);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("load_mem_rd_drop", {31'd0, mem_rd}, 0);

        // PUSH x2 then POP
        issue(8'b10_000_000, k);
        chk("push1_sp", {24'd0, sp}, 32'hFE);
        chk("push1_ready", {31'd0, instr_ready}, 1);
        issue(8'b10_000_000, k);
        chk("push2_sp", {24'd0, sp}, 32'hFD);
        issue(8'b00_000_100, k);
        push_ev(K_WR, 3'b100, 3'd0, k);
        @(negedge clk);
        chk("pop_sp_during_write", {24'd0, sp}, 32'hFD);
        @(negedge clk);
        chk("pop_sp_after", {24'd0, sp}, 32'hFE);

        // READ R2
        issue(8'b01_010_000, k);
        push_ev(K_RD, 3'b000, 3'd2, k + 1);
        @(negedge clk);
        chk("read_seg_in_read", {29'd0, read_seg}, 2);
        chk("read_no_valid_yet", {31'd0, rd_valid}, 0);
        @(negedge clk);

        // Illegal opcodes
        issue(8'hC0, k);
        push_ev(K_ERR, 3'b000, 3'd0, k);
        issue(8'b00_010_111, k);
        push_ev(K_ERR, 3'b000, 3'd0, k);
        @(negedge clk);
        chk("read_seg_held", {29'd0, read_seg}, 2);

        // Stray mem_ack while idle must not trigger anything
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_mem_rd", {31'd0, mem_rd}, 0);

        // sp wrap: FE -> FF -> 00 via POP, 00 -> FF via PUSH
        for (int i = 0; i < 2; i++) begin
            issue(8'b00_000_100, k);
            push_ev(K_WR, 3'b100, 3'd0, k);
            repeat (2) @(negedge clk);
        end
        chk("sp_wrap_up", {24'd0, sp}, 32'h00);
        issue(8'b10_000_000, k);
        chk("sp_wrap_down", {24'd0, sp}, 32'hFF);

        // LOAD with no ack
        issue(8'b00_110_110, k);
`ifdef REGSEQ_MEMTO_EN
        push_ev(K_ERR, 3'b000, 3'd0, k + 16);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_rd) cnt++;
        end
        chk("timeout_mem_rd_cycles", cnt, 16);
`else
        push_ev(K_WR, 3'b110, 3'd6, k + 20);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_rd) cnt++;
        end
        chk("no_timeout_mem_rd_cycles", cnt, 20);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
`endif

        // Reset mid-LOAD after moving sp off its reset value
        issue(8'b10_000_000, k);
        chk("pre_reset_sp", {24'd0, sp}, 32'hFE);
        issue(8'b00_001_110, k);
        @(negedge clk);
        @(negedge clk);
        chk("midload_mem_rd", {31'd0, mem_rd}, 1);
        #2;
        clr = 1'b1;
        #1;
        chk_reset_outputs("midload_reset");
        @(negedge clk);
        clr = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_reset_mem_rd", {31'd0, mem_rd}, 0);

        cnt = 0;
        while (q.size() != 0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("scoreboard_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
